// File: rtl/pdm_cic_decimator.sv
// PDM microphone front-end: mic clock generation, per-edge channel sampling and a
// 2nd-order CIC decimator per channel producing signed PCM samples.
module pdm_cic_decimator #(
  parameter int unsigned CLK_DIV = 32,
  parameter int unsigned DECIM   = 64,
  parameter int unsigned NUM_CH  = 1,
  parameter int unsigned OUT_W   = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    en_in,
  input  logic                    mic_data_in,
  output logic                    mic_clk_out,
  output logic                    sample_valid_out,
  output logic signed [OUT_W-1:0] left_out,
  output logic signed [OUT_W-1:0] right_out
);

  localparam int unsigned LogD = $clog2(DECIM);
  localparam int unsigned W    = 2 * LogD + 2;
  localparam int unsigned CntW = $clog2(CLK_DIV);

  localparam logic [CntW-1:0] CntLast  = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] CntHalf  = CntW'(CLK_DIV / 2);
  localparam logic [CntW-1:0] CntRight = CntW'(CLK_DIV / 2 - 1);
  localparam logic [LogD-1:0] DecLast  = LogD'(DECIM - 1);

  logic [CntW-1:0]         cnt_q;
  logic                    r_arm_q;
  logic [1:0]              tick;
  logic [1:0]              dump_q;
  logic [LogD-1:0]         dcnt_q [2];
  logic signed [W-1:0]     i1_q   [2];
  logic signed [W-1:0]     i2_q   [2];
  logic signed [W-1:0]     d1_q   [2];
  logic signed [W-1:0]     d2_q   [2];
  logic signed [W-1:0]     c1     [2];
  logic signed [W-1:0]     c2     [2];
  logic signed [W-1:0]     x;
  logic signed [OUT_W-1:0] left_hold_q;

  // Appending OUT_W zeros then taking the top OUT_W bits covers both truncation
  // (W >= OUT_W) and left shift (W < OUT_W) without width-dependent branches.
  function automatic logic signed [OUT_W-1:0] scale(input logic signed [W-1:0] v);
    logic [W+OUT_W-1:0] ext;
    ext = {v, {OUT_W{1'b0}}};
    return ext[W+OUT_W-1 -: OUT_W];
  endfunction

  always_comb begin
    x = mic_data_in ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};
    tick[0] = en_in && (cnt_q == CntLast);
    // Right channel is armed by the first left tick so its dump trails the left dump.
    tick[1] = (NUM_CH == 2) && en_in && r_arm_q && (cnt_q == CntRight);
    for (int ch = 0; ch < 2; ch++) begin
      c1[ch] = i2_q[ch] - d1_q[ch];
      c2[ch] = c1[ch] - d2_q[ch];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in || !en_in) begin
      cnt_q            <= '0;
      r_arm_q          <= 1'b0;
      dump_q           <= '0;
      mic_clk_out      <= 1'b0;
      sample_valid_out <= 1'b0;
      left_out         <= '0;
      right_out        <= '0;
      left_hold_q      <= '0;
      for (int ch = 0; ch < 2; ch++) begin
        dcnt_q[ch] <= '0;
        i1_q[ch]   <= '0;
        i2_q[ch]   <= '0;
        d1_q[ch]   <= '0;
        d2_q[ch]   <= '0;
      end
    end else begin
      cnt_q       <= (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
      mic_clk_out <= (cnt_q < CntHalf);
      if (tick[0]) r_arm_q <= 1'b1;

      for (int ch = 0; ch < 2; ch++) begin
        dump_q[ch] <= tick[ch] && (dcnt_q[ch] == DecLast);
        if (tick[ch]) begin
          i1_q[ch]   <= i1_q[ch] + x;
          i2_q[ch]   <= i2_q[ch] + i1_q[ch];
          dcnt_q[ch] <= dcnt_q[ch] + LogD'(1);
        end
        if (dump_q[ch]) begin
          d1_q[ch] <= i2_q[ch];
          d2_q[ch] <= c1[ch];
        end
      end

      sample_valid_out <= 1'b0;
      if (NUM_CH == 2) begin
        if (dump_q[0]) left_hold_q <= scale(c2[0]);
        if (dump_q[1]) begin
          left_out         <= left_hold_q;
          right_out        <= scale(c2[1]);
          sample_valid_out <= 1'b1;
        end
      end else if (dump_q[0]) begin
        left_out         <= scale(c2[0]);
        sample_valid_out <= 1'b1;
      end
    end
  end

endmodule
